// File: rtl/fwd_hazard_pkg.sv
// Shared types and helpers for the forwarding/hazard unit: stall FSM states,
// the register-file select code and the stage-to-select encoding.
package fwd_hazard_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } fsm_state_e;

  localparam int unsigned SEL_RF = 0;

  // Stage k (0 = youngest) is selected with code k+1; code 0 is the register file.
  function automatic int unsigned stage_sel(input int unsigned k);
    return k + 1;
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Per-source producer search: finds the youngest stage writing this source's
// register and returns its bypass select plus whether the source must wait.
module fwd_src_match
  import fwd_hazard_pkg::*;
#(
  parameter int REG_AW     = 4,
  parameter int FWD_STAGES = 2,
  parameter int SEL_W      = $clog2(FWD_STAGES+1)
) (
  input  logic [REG_AW-1:0]            src_addr_i,
  input  logic                         src_valid_i,
  input  logic [FWD_STAGES*REG_AW-1:0] stage_dest_i,
  input  logic [FWD_STAGES-1:0]        stage_wb_en_i,
  input  logic [FWD_STAGES-1:0]        stage_rdy_i,
  input  logic                         fwd_mode_i,
  output logic [SEL_W-1:0]             sel_o,
  output logic                         hazard_o
);

  // Scan oldest to youngest so the youngest match is written last and wins.
  always_comb begin
    sel_o    = SEL_W'(SEL_RF);
    hazard_o = 1'b0;
    for (int k = FWD_STAGES-1; k >= 0; k--) begin
      if (src_valid_i && stage_wb_en_i[k] &&
          (src_addr_i == stage_dest_i[k*REG_AW +: REG_AW])) begin
        if (fwd_mode_i) begin
          sel_o    = SEL_W'(stage_sel(k));
          hazard_o = ~stage_rdy_i[k];
        end else begin
          sel_o    = SEL_W'(SEL_RF);
          hazard_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and data-hazard stall for the ID/EX boundary, with a stall
// episode FSM, run-length counter and sticky timeout. Optional performance
// counters are built when FWD_HAZARD_PERF_EN is defined.
module fwd_hazard_unit
  import fwd_hazard_pkg::*;
#(
  parameter int REG_AW     = 4,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int SEL_W      = $clog2(FWD_STAGES+1),
  parameter int MAX_STALL  = 15,
  parameter int CNT_W      = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_SRC*REG_AW-1:0]      src_addr_i,
  input  logic [NUM_SRC-1:0]             src_valid_i,
  input  logic [FWD_STAGES*REG_AW-1:0]   stage_dest_i,
  input  logic [FWD_STAGES-1:0]          stage_wb_en_i,
  input  logic [FWD_STAGES-1:0]          stage_rdy_i,
  input  logic                           fwd_mode_i,
  input  logic                           flush_i,
  output logic [NUM_SRC*SEL_W-1:0]       sel_src_o,
  output logic                           hazard_stall_o,
  output logic [$clog2(MAX_STALL+1)-1:0] stall_run_o,
  output logic                           stall_timeout_o,
  output logic [CNT_W-1:0]               perf_stall_cnt_o,
  output logic [CNT_W-1:0]               perf_fwd_cnt_o
);

  localparam int RUN_W = $clog2(MAX_STALL+1);

  logic [NUM_SRC-1:0][SEL_W-1:0] sel_raw;
  logic [NUM_SRC-1:0]            haz_raw;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_match #(
      .REG_AW     (REG_AW),
      .FWD_STAGES (FWD_STAGES),
      .SEL_W      (SEL_W)
    ) u_match (
      .src_addr_i    (src_addr_i[i*REG_AW +: REG_AW]),
      .src_valid_i   (src_valid_i[i]),
      .stage_dest_i  (stage_dest_i),
      .stage_wb_en_i (stage_wb_en_i),
      .stage_rdy_i   (stage_rdy_i),
      .fwd_mode_i    (fwd_mode_i),
      .sel_o         (sel_raw[i]),
      .hazard_o      (haz_raw[i])
    );
  end

  // Flush only kills the stall; the bypass selects stay live for the squashed slot.
  assign sel_src_o      = rst_i ? '0 : sel_raw;
  assign hazard_stall_o = (|haz_raw) & ~flush_i & ~rst_i;

  fsm_state_e       state_q, state_d;
  logic [RUN_W-1:0] stall_run_q, stall_run_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (hazard_stall_o)  state_d = ST_STALL;
      ST_STALL: if (!hazard_stall_o) state_d = ST_RUN;
      default:                       state_d = ST_RUN;
    endcase
    if (flush_i) state_d = ST_RUN;

    stall_run_d = '0;
    if (state_d == ST_STALL)
      stall_run_d = (stall_run_q == RUN_W'(MAX_STALL)) ? stall_run_q
                                                       : stall_run_q + RUN_W'(1);
    // Only a registered run that actually reaches the limit trips the flag.
    timeout_d = timeout_q | (stall_run_d == RUN_W'(MAX_STALL));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      stall_run_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_run_q <= stall_run_d;
      timeout_q   <= timeout_d;
    end
  end

  assign stall_run_o     = stall_run_q;
  assign stall_timeout_o = timeout_q;

`ifdef FWD_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, fwd_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (hazard_stall_o)                   stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if ((|sel_src_o) && !hazard_stall_o)  fwd_cnt_q   <= fwd_cnt_q + CNT_W'(1);
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_fwd_cnt_o   = fwd_cnt_q;
`else
  assign perf_stall_cnt_o = '0;
  assign perf_fwd_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed plus randomized bench for fwd_hazard_unit against a cycle-level
// reference model built from the forwarding/stall rules.
module tb_fwd_hazard_unit;

  localparam int REG_AW     = 4;
  localparam int NUM_SRC    = 2;
  localparam int FWD_STAGES = 2;
  localparam int SEL_W      = $clog2(FWD_STAGES+1);
  localparam int MAX_STALL  = 15;
  localparam int CNT_W      = 16;
  localparam int RUN_W      = $clog2(MAX_STALL+1);

  logic                         clk = 1'b0;
  logic                         rst;
  logic [NUM_SRC*REG_AW-1:0]    src_addr;
  logic [NUM_SRC-1:0]           src_valid;
  logic [FWD_STAGES*REG_AW-1:0] stage_dest;
  logic [FWD_STAGES-1:0]        stage_wb_en;
  logic [FWD_STAGES-1:0]        stage_rdy;
  logic                         fwd_mode;
  logic                         flush;
  logic [NUM_SRC*SEL_W-1:0]     sel_src;
  logic                         hazard_stall;
  logic [RUN_W-1:0]             stall_run;
  logic                         stall_timeout;
  logic [CNT_W-1:0]             perf_stall_cnt;
  logic [CNT_W-1:0]             perf_fwd_cnt;

  fwd_hazard_unit #(
    .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .FWD_STAGES(FWD_STAGES),
    .SEL_W(SEL_W), .MAX_STALL(MAX_STALL), .CNT_W(CNT_W)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .src_addr_i       (src_addr),
    .src_valid_i      (src_valid),
    .stage_dest_i     (stage_dest),
    .stage_wb_en_i    (stage_wb_en),
    .stage_rdy_i      (stage_rdy),
    .fwd_mode_i       (fwd_mode),
    .flush_i          (flush),
    .sel_src_o        (sel_src),
    .hazard_stall_o   (hazard_stall),
    .stall_run_o      (stall_run),
    .stall_timeout_o  (stall_timeout),
    .perf_stall_cnt_o (perf_stall_cnt),
    .perf_fwd_cnt_o   (perf_fwd_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state
  int          m_run  = 0;
  bit          m_to   = 0;
  logic [15:0] m_scnt = '0;
  logic [15:0] m_fcnt = '0;
  int          e_sel [NUM_SRC];
  bit          e_haz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_src(input int i, input int addr, input bit v);
    src_addr[i*REG_AW +: REG_AW] = REG_AW'(addr);
    src_valid[i] = v;
  endtask

  task automatic set_stage(input int k, input int dest, input bit wb, input bit rdy);
    stage_dest[k*REG_AW +: REG_AW] = REG_AW'(dest);
    stage_wb_en[k] = wb;
    stage_rdy[k]   = rdy;
  endtask

  // Youngest matching producer decides each source; the stall is the OR over sources.
  task automatic model_comb();
    bit any = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      e_sel[i] = 0;
      if (rst) continue;
      for (int k = 0; k < FWD_STAGES; k++) begin
        if (src_valid[i] && stage_wb_en[k] &&
            src_addr[i*REG_AW +: REG_AW] == stage_dest[k*REG_AW +: REG_AW]) begin
          e_sel[i] = fwd_mode ? k + 1 : 0;
          if (!fwd_mode || !stage_rdy[k]) any = 1;
          break;
        end
      end
    end
    e_haz = any && !flush && !rst;
  endtask

  task automatic step();
    bit any_sel = 0;
    #1;
    model_comb();
    for (int i = 0; i < NUM_SRC; i++) begin
      check($sformatf("sel_src%0d", i), 32'(sel_src[i*SEL_W +: SEL_W]), 32'(e_sel[i]));
      if (e_sel[i] != 0) any_sel = 1;
    end
    check("hazard_stall", 32'(hazard_stall), 32'(e_haz));
    @(posedge clk);
    if (rst) begin
      m_run = 0; m_to = 0; m_scnt = '0; m_fcnt = '0;
    end else begin
      m_run = e_haz ? ((m_run < MAX_STALL) ? m_run + 1 : MAX_STALL) : 0;
      if (m_run == MAX_STALL) m_to = 1;
`ifdef FWD_HAZARD_PERF_EN
      if (e_haz) m_scnt = m_scnt + 16'd1;
      if (any_sel && !e_haz) m_fcnt = m_fcnt + 16'd1;
`endif
    end
    #1;
    check("stall_run", 32'(stall_run), 32'(m_run));
    check("stall_timeout", 32'(stall_timeout), 32'(m_to));
    check("perf_stall_cnt", 32'(perf_stall_cnt), 32'(m_scnt));
    check("perf_fwd_cnt", 32'(perf_fwd_cnt), 32'(m_fcnt));
  endtask

  task automatic idle_inputs();
    src_valid = '0; src_addr = '0;
    stage_wb_en = '0; stage_rdy = '0; stage_dest = '0;
    fwd_mode = 1'b1; flush = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;

    // Reset with a live hazard on the inputs: outputs must stay masked.
    set_src(0, 3, 1); set_stage(0, 3, 1, 0);
    step(); step();
    check("rst_hazard_masked", 32'(hazard_stall), 32'd0);
    check("rst_sel_masked", 32'(sel_src), 32'd0);
    rst = 1'b0;

    // Simple forward from EX.
    idle_inputs(); set_src(0, 3, 1); set_stage(0, 3, 1, 1);
    step();
    check("fwd_ex_sel0", 32'(sel_src[0 +: SEL_W]), 32'd1);
    check("fwd_ex_run", 32'(stall_run), 32'd0);

    // Youngest wins, then fall back to the MEM stage.
    idle_inputs(); set_src(1, 5, 1); set_stage(0, 5, 1, 1); set_stage(1, 5, 1, 1);
    step();
    check("youngest_sel1", 32'(sel_src[SEL_W +: SEL_W]), 32'd1);
    set_stage(0, 6, 1, 1);
    step();
    check("mem_sel1", 32'(sel_src[SEL_W +: SEL_W]), 32'd2);

    // Register 0 forwards like any other register.
    idle_inputs(); set_src(1, 0, 1); set_stage(1, 0, 1, 1);
    step();
    check("r0_sel1", 32'(sel_src[SEL_W +: SEL_W]), 32'd2);

    // Load-use for three cycles.
    idle_inputs(); set_src(0, 2, 1); set_stage(0, 2, 1, 0);
    for (int c = 1; c <= 3; c++) begin
      step();
      check($sformatf("loaduse_run%0d", c), 32'(stall_run), 32'(c));
    end
    set_stage(0, 2, 1, 1);
    step();
    check("loaduse_clear_run", 32'(stall_run), 32'd0);

    // Hazard just clearing as the run would reach MAX: no timeout yet.
    set_stage(0, 2, 1, 0);
    for (int c = 0; c < MAX_STALL-1; c++) step();
    check("pre_sat_run", 32'(stall_run), 32'(MAX_STALL-1));
    set_stage(0, 2, 1, 1);
    step();
    check("near_sat_no_timeout", 32'(stall_timeout), 32'd0);

    // Long stall saturates and sets the sticky timeout.
    set_stage(0, 2, 1, 0);
    for (int c = 0; c < 20; c++) step();
    check("sat_run", 32'(stall_run), 32'(MAX_STALL));
    check("sat_timeout", 32'(stall_timeout), 32'd1);
    set_stage(0, 2, 1, 1);
    step(); step();
    check("timeout_sticky", 32'(stall_timeout), 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    check("timeout_rst", 32'(stall_timeout), 32'd0);

    // Stall-only mode, then flush in the same cycle.
    idle_inputs(); fwd_mode = 1'b0; set_src(0, 4, 1); set_stage(1, 4, 1, 1);
    step();
    check("nofwd_sel0", 32'(sel_src[0 +: SEL_W]), 32'd0);
    check("nofwd_run", 32'(stall_run), 32'd1);
    flush = 1'b1;
    step();
    check("flush_run", 32'(stall_run), 32'd0);

    // Four stall cycles plus two forward-only cycles, then reset counters.
    rst = 1'b1; step(); rst = 1'b0;
    idle_inputs(); set_src(0, 7, 1); set_stage(0, 7, 1, 0);
    for (int c = 0; c < 4; c++) step();
    set_stage(0, 7, 1, 1);
    for (int c = 0; c < 2; c++) step();
`ifdef FWD_HAZARD_PERF_EN
    check("perf_stall4", 32'(perf_stall_cnt), 32'd4);
    check("perf_fwd2", 32'(perf_fwd_cnt), 32'd2);
`else
    check("perf_stall_off", 32'(perf_stall_cnt), 32'd0);
    check("perf_fwd_off", 32'(perf_fwd_cnt), 32'd0);
`endif
    rst = 1'b1; step(); rst = 1'b0;
    check("perf_rst", 32'(perf_stall_cnt) | 32'(perf_fwd_cnt), 32'd0);

    // Randomized traffic on a small register window to force frequent matches.
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < NUM_SRC; i++)
        set_src(i, $urandom_range(0, 3), $urandom_range(0, 3) != 0);
      for (int k = 0; k < FWD_STAGES; k++)
        set_stage(k, $urandom_range(0, 3), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 2) != 0);
      fwd_mode = ($urandom_range(0, 4) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      rst      = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
